// File: rtl/cw305_reg_cmd_master_pkg.sv
// cw305 register-bus command master: opcodes, state encoding, helpers.
// REG_CMD_MASTER_ACK_EN adds the write-acknowledge state.
package cw305_reg_cmd_master_pkg;

  localparam logic [7:0] CMD_OP_WRITE = 8'h00;
  localparam logic [7:0] CMD_OP_READ = 8'h80;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_LEN,
    ST_WR_WAIT,
    ST_WR_STROBE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_RD_SEND
`ifdef REG_CMD_MASTER_ACK_EN
    ,
    ST_ACK
`endif
  } state_t;

  // States that present in_ready and consume command bytes.
  function automatic logic takes_input(input state_t s);
    return s inside {ST_IDLE, ST_ADDR_LO, ST_ADDR_HI,
                     ST_LEN, ST_WR_WAIT};
  endfunction

endpackage

// File: rtl/cw305_reg_cmd_master_out.sv
// Single-entry valid/ready holding register for response bytes.
// Shared by the read-return and write-acknowledge paths.
module cw305_cmd_out_reg
  import cw305_reg_cmd_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cw305_reg_cmd_master.sv
// Byte-stream command parser driving the cw305 register strobe bus.
// REG_CMD_MASTER_ACK_EN: emit pACK_BYTE after each completed write.
module cw305_reg_cmd_master
  import cw305_reg_cmd_master_pkg::*;
#(
  parameter int         pADDR_WIDTH   = 21,
  parameter int         pBYTECNT_SIZE = 8,
  parameter logic [7:0] pACK_BYTE     = ACK_BYTE_DEFAULT
) (
  input  logic                             usb_clk,
  input  logic                             reset_i,
  input  logic [7:0]                       I_in_data,
  input  logic                             I_in_valid,
  output logic                             O_in_ready,
  output logic [7:0]                       O_out_data,
  output logic                             O_out_valid,
  input  logic                             I_out_ready,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]         reg_bytecnt,
  output logic [7:0]                       write_data,
  input  logic [7:0]                       read_data,
  output logic                             reg_read,
  output logic                             reg_write,
  output logic                             reg_addrvalid,
  output logic                             O_busy,
  output logic                             O_cmd_err
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BW = pBYTECNT_SIZE;

  state_t          state_q, state_n;
  logic            is_wr_q, is_wr_n;
  logic [7:0]      lo_q, lo_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [7:0]      remain_q, remain_n;
  logic [AW-1:0]   raddr_n;
  logic [BW-1:0]   bcnt_n;
  logic [7:0]      wdata_n;
  logic            av_n, rd_n, wr_n, err_n;
  logic            in_take, out_take;
  logic            out_load;
  logic [7:0]      out_load_data;

  cw305_cmd_out_reg u_out (
    .clk       (usb_clk),
    .rst       (reset_i),
    .load      (out_load),
    .load_data (out_load_data),
    .data      (O_out_data),
    .valid     (O_out_valid),
    .ready     (I_out_ready)
  );

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      is_wr_q       <= 1'b0;
      lo_q          <= 8'h00;
      addr_q        <= '0;
      remain_q      <= 8'h00;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= 8'h00;
      reg_addrvalid <= 1'b0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      O_cmd_err     <= 1'b0;
      O_in_ready    <= 1'b0;
      O_busy        <= 1'b0;
    end else begin
      state_q       <= state_n;
      is_wr_q       <= is_wr_n;
      lo_q          <= lo_n;
      addr_q        <= addr_n;
      remain_q      <= remain_n;
      reg_address   <= raddr_n;
      reg_bytecnt   <= bcnt_n;
      write_data    <= wdata_n;
      reg_addrvalid <= av_n;
      reg_read      <= rd_n;
      reg_write     <= wr_n;
      O_cmd_err     <= err_n;
      O_in_ready    <= takes_input(state_n);
      O_busy        <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n       = state_q;
    is_wr_n       = is_wr_q;
    lo_n          = lo_q;
    addr_n        = addr_q;
    remain_n      = remain_q;
    raddr_n       = reg_address;
    bcnt_n        = reg_bytecnt;
    wdata_n       = write_data;
    av_n          = reg_addrvalid;
    rd_n          = 1'b0;
    wr_n          = 1'b0;
    err_n         = 1'b0;
    out_load      = 1'b0;
    out_load_data = read_data;
    in_take       = I_in_valid && O_in_ready;
    out_take      = O_out_valid && I_out_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (in_take) begin
          if (I_in_data == CMD_OP_WRITE ||
              I_in_data == CMD_OP_READ) begin
            is_wr_n = (I_in_data == CMD_OP_WRITE);
            state_n = ST_ADDR_LO;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_ADDR_LO: begin
        if (in_take) begin
          lo_n    = I_in_data;
          state_n = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (in_take) begin
          // High address bits beyond the register width are dropped.
          addr_n  = AW'({I_in_data, lo_q});
          state_n = ST_LEN;
        end
      end
      ST_LEN: begin
        if (in_take) begin
          remain_n = I_in_data;
          raddr_n  = addr_q;
          bcnt_n   = '0;
          av_n     = 1'b1;
          if (is_wr_q) begin
            state_n = ST_WR_WAIT;
          end else begin
            rd_n    = 1'b1;
            state_n = ST_RD_ISSUE;
          end
        end
      end
      ST_WR_WAIT: begin
        if (in_take) begin
          wdata_n = I_in_data;
          wr_n    = 1'b1;
          state_n = ST_WR_STROBE;
        end
      end
      ST_WR_STROBE: begin
        if (remain_q == 8'h00) begin
`ifdef REG_CMD_MASTER_ACK_EN
          out_load      = 1'b1;
          out_load_data = pACK_BYTE;
          state_n       = ST_ACK;
`else
          av_n    = 1'b0;
          state_n = ST_IDLE;
`endif
        end else begin
          bcnt_n   = reg_bytecnt + 1'b1;
          remain_n = remain_q - 8'd1;
          state_n  = ST_WR_WAIT;
        end
      end
      ST_RD_ISSUE: begin
        state_n = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
        out_load = 1'b1;
        state_n  = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (out_take) begin
          if (remain_q == 8'h00) begin
            av_n    = 1'b0;
            state_n = ST_IDLE;
          end else begin
            bcnt_n   = reg_bytecnt + 1'b1;
            remain_n = remain_q - 8'd1;
            rd_n     = 1'b1;
            state_n  = ST_RD_ISSUE;
          end
        end
      end
`ifdef REG_CMD_MASTER_ACK_EN
      ST_ACK: begin
        if (out_take) begin
          av_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
`endif
      default: begin
        av_n    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cw305_reg_cmd_master.sv
// Scoreboard bench for cw305_reg_cmd_master: random command streams
// checked against a transaction-level model of the register bus.
`timescale 1ns/1ps
module tb_cw305_reg_cmd_master;

  localparam int AW = 13;
  localparam int BW = 8;

  logic          usb_clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [7:0]    I_in_data = 8'h00;
  logic          I_in_valid = 1'b0;
  logic          O_in_ready;
  logic [7:0]    O_out_data;
  logic          O_out_valid;
  logic          I_out_ready;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    write_data;
  logic [7:0]    read_data = 8'h00;
  logic          reg_read;
  logic          reg_write;
  logic          reg_addrvalid;
  logic          O_busy;
  logic          O_cmd_err;

  always #5 usb_clk = ~usb_clk;

  cw305_reg_cmd_master #(
    .pADDR_WIDTH   (21),
    .pBYTECNT_SIZE (8),
    .pACK_BYTE     (8'hA5)
  ) dut (
    .usb_clk       (usb_clk),
    .reset_i       (reset_i),
    .I_in_data     (I_in_data),
    .I_in_valid    (I_in_valid),
    .O_in_ready    (O_in_ready),
    .O_out_data    (O_out_data),
    .O_out_valid   (O_out_valid),
    .I_out_ready   (I_out_ready),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .O_busy        (O_busy),
    .O_cmd_err     (O_cmd_err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    bc;
    logic [7:0]    d;
  } wr_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    bc;
  } rd_t;

  wr_t        exp_wr[$];
  rd_t        exp_rd[$];
  logic [7:0] exp_out[$];
  logic [7:0] wdata_q[$];
  int         exp_err = 0;
  int         errors = 0;
  int         checks = 0;
  int         stall_len = 0;
  wr_t        mw;
  rd_t        mr;
  logic [7:0] mo;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", nm);
  endfunction

  // Responder contents: distinct per address and byte index.
  function automatic logic [7:0] resp(input logic [AW-1:0] a,
                                      input logic [7:0] bc);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'(bc * 8'd3) ^ 8'h2A;
  endfunction

  // Data is only meaningful the cycle after reg_read.
  always @(posedge usb_clk) begin
    if (reg_read) read_data <= resp(reg_address, reg_bytecnt);
    else read_data <= 8'($urandom);
  end

  initial begin
    int wc;
    wc = 0;
    I_out_ready = 1'b0;
    forever begin
      @(posedge usb_clk);
      #1;
      if (O_out_valid) wc++;
      else wc = 0;
      if (stall_len > 0) I_out_ready = (wc > stall_len);
      else I_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge usb_clk) begin
    if (!reset_i) begin
      if (reg_write || reg_read) begin
        chk("strobe_addrvalid", reg_addrvalid, 1);
        chk("strobe_exclusive", reg_read & reg_write, 0);
      end
      if (reg_write) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          mw = exp_wr.pop_front();
          chk("wr_address", reg_address, mw.a);
          chk("wr_bytecnt", reg_bytecnt, mw.bc);
          chk("wr_data", write_data, mw.d);
        end
      end
      if (reg_read) begin
        chk("rd_while_out_valid", O_out_valid, 0);
        if (exp_rd.size() == 0) flag("unexpected_read");
        else begin
          mr = exp_rd.pop_front();
          chk("rd_address", reg_address, mr.a);
          chk("rd_bytecnt", reg_bytecnt, mr.bc);
        end
      end
      if (O_out_valid && I_out_ready) begin
        if (exp_out.size() == 0) flag("unexpected_out");
        else begin
          mo = exp_out.pop_front();
          chk("out_data", O_out_data, mo);
        end
      end
      if (O_cmd_err) begin
        if (exp_err == 0) flag("unexpected_cmd_err");
        else begin
          checks++;
          exp_err--;
        end
      end
    end
  end

  function automatic logic pending();
    return O_busy || O_out_valid || exp_wr.size() != 0 ||
           exp_rd.size() != 0 || exp_out.size() != 0 ||
           exp_err != 0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 1)) begin
      @(posedge usb_clk);
      #1;
    end
    I_in_data = b;
    I_in_valid = 1'b1;
    @(negedge usb_clk);
    while (!O_in_ready && n < 2000) begin
      @(negedge usb_clk);
      n++;
    end
    if (!O_in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: ready=0 required 1");
    end
    @(posedge usb_clk);
    #1;
    I_in_valid = 1'b0;
  endtask

  task automatic cmd_write(input logic [15:0] a, input int len);
    for (int i = 0; i <= len; i++)
      exp_wr.push_back('{a: a[AW-1:0], bc: 8'(i), d: wdata_q[i]});
`ifdef REG_CMD_MASTER_ACK_EN
    exp_out.push_back(8'hA5);
`endif
    send_byte(8'h00);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(8'(len));
    for (int i = 0; i <= len; i++) send_byte(wdata_q[i]);
  endtask

  task automatic cmd_read(input logic [15:0] a, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_rd.push_back('{a: a[AW-1:0], bc: 8'(i)});
      exp_out.push_back(resp(a[AW-1:0], 8'(i)));
    end
    send_byte(8'h80);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(8'(len));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge usb_clk);
      n++;
    end while (pending() && n < budget);
    chk("drain_timeout", pending(), 0);
    chk("addrvalid_idle", reg_addrvalid, 0);
    @(posedge usb_clk);
    #1;
  endtask

  initial begin
    int op, len;
    logic [15:0] a;
    logic [7:0] b;

    repeat (3) @(posedge usb_clk);
    @(negedge usb_clk);
    chk("rst_in_ready", O_in_ready, 0);
    chk("rst_out_valid", O_out_valid, 0);
    chk("rst_strobes", {reg_read, reg_write, reg_addrvalid}, 0);
    chk("rst_busy_err", {O_busy, O_cmd_err}, 0);
    chk("rst_bus", {reg_address, reg_bytecnt, write_data}, 0);
    @(posedge usb_clk);
    #1;
    reset_i = 1'b0;
    @(negedge usb_clk);
    chk("in_ready_before_edge", O_in_ready, 0);
    @(negedge usb_clk);
    chk("in_ready_after_reset", O_in_ready, 1);
    @(posedge usb_clk);
    #1;

    wdata_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd_write(16'h0006, 3);
    wait_idle(400);

    cmd_read(16'h0004, 0);
    wait_idle(400);

    exp_err++;
    send_byte(8'h41);
    wait_idle(100);
    wdata_q = '{8'h5A};
    cmd_write(16'h1234, 0);
    wait_idle(400);

    exp_wr.push_back('{a: 13'h0008, bc: 8'h00, d: 8'hAA});
    exp_wr.push_back('{a: 13'h0008, bc: 8'h01, d: 8'hBB});
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (3) @(posedge usb_clk);
    #1;
    reset_i = 1'b1;
    @(posedge usb_clk);
    #1;
    reset_i = 1'b0;
    @(negedge usb_clk);
    chk("midrst_strobes", {reg_read, reg_write, reg_addrvalid}, 0);
    chk("midrst_busy", O_busy, 0);
    chk("midrst_out_valid", O_out_valid, 0);
    chk("midrst_wr_drained", exp_wr.size(), 0);
    @(posedge usb_clk);
    #1;
    exp_err += 2;
    send_byte(8'h33);
    send_byte(8'h44);
    wait_idle(200);

    stall_len = 10;
    cmd_read(16'hEABC, 255);
    wait_idle(10000);
    stall_len = 0;

    repeat (25) begin
      op = $urandom_range(0, 2);
      a = 16'($urandom);
      len = $urandom_range(0, 5);
      if (op == 0) begin
        wdata_q.delete();
        for (int i = 0; i <= len; i++) wdata_q.push_back(8'($urandom));
        cmd_write(a, len);
      end else if (op == 1) begin
        cmd_read(a, len);
      end else begin
        b = 8'($urandom_range(1, 127));
        if ($urandom_range(0, 1) == 1) b = b | 8'h80;
        exp_err++;
        send_byte(b);
      end
      wait_idle(1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
